verificador_hash: RTL and testbench
===================================

Name: verificador_hash

Overview:
- Read-side checker for the 8-bit XOR line hash that is generated when a 512-bit cache line is written.
- Receives a cache line as a stream of beats over a valid/ready handshake, together with the stored hash, and folds the beats into a running XOR.
- Reports the computed hash, a match flag and a framing error.
- Sits between the cache data array read port and the integrity-error logic.

Parameters:
- LARGURA_LINHA, 512: cache line width in bits; multiple of LARGURA_BEAT.
- LARGURA_BEAT, 64: beat width in bits; multiple of 8.
- NUM_BEATS, LARGURA_LINHA/LARGURA_BEAT: localparam, beats per line (8 at defaults).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- entrada_valida  input  1  beat valid.
- entrada_pronta  output  1  beat ready.
- entrada_dados  input  LARGURA_BEAT  line beat; beat 0 carries line bits [LARGURA_BEAT-1:0].
- entrada_ultimo  input  1  marks the final beat of a line.
- hash_esperado  input  8  stored hash; sampled only with beat 0.
- saida_valida  output  1  result valid.
- saida_pronta  input  1  result consumed.
- hash_calculado  output  8  XOR of all line bytes.
- hash_ok  output  1  hash_calculado == captured hash_esperado, and no framing error.
- erro_enquadramento  output  1  entrada_ultimo was misplaced.

Behaviour:
- Hash definition: XOR over k = 0..LARGURA_LINHA/8-1 of line[8k+7:8k]. Because XOR is order-independent, beat order does not affect the value.
- Handshake rules:
  - Beat accepted when entrada_valida & entrada_pronta.
  - Result consumed when saida_valida & saida_pronta.
  - entrada_pronta = (estado != RESULTADO).
- FSM states: OCIOSO, ACUMULANDO, RESULTADO.
- OCIOSO:
  - On accept: acc <= fold(beat), esperado <= hash_esperado, cont <= 1.
  - If the line ends on this beat (entrada_ultimo, or NUM_BEATS == 1): go to RESULTADO; otherwise go to ACUMULANDO.
- ACUMULANDO:
  - On accept: acc <= acc ^ fold(beat), cont <= cont + 1.
  - Go to RESULTADO when entrada_ultimo or cont == NUM_BEATS-1.
  - Cycles with no beat accepted hold all state.
- Framing error: erro_enquadramento is set when the terminating beat has entrada_ultimo != (cont == NUM_BEATS-1), i.e. ultimo arrives early or is missing on the last beat.
  - Early ultimo terminates the line short.
  - A missing ultimo terminates the line at NUM_BEATS beats; the next beat is treated as beat 0 of a new line.
- RESULTADO:
  - saida_valida = 1.
  - hash_calculado, hash_ok and erro_enquadramento are registered and held stable while saida_pronta = 0.
  - Return to OCIOSO on consume.
- Latency and throughput:
  - saida_valida rises the cycle after the terminating beat is accepted.
  - Entry is not accepted during RESULTADO, so back-to-back lines cost NUM_BEATS+1 cycles minimum with saida_pronta tied high.
- cont width: clog2(NUM_BEATS) bits, minimum 1. It never wraps because the line terminates at NUM_BEATS-1.
- Reset (asynchronous, rst_n low):
  - estado = OCIOSO; acc, esperado and cont = 0.
  - saida_valida = 0, hash_calculado = 0x00, hash_ok = 0, erro_enquadramento = 0.
  - entrada_pronta reads 1.
- Reset mid-line or mid-result discards the partial line or pending result with no output.
- Inputs other than the handshake are don't-care while their valid is low.

Decomposition:
- Shared package:
  - LARGURA_HASH = 8.
  - State enum type (OCIOSO/ACUMULANDO/RESULTADO).
  - Function or constant for NUM_BEATS.
- One combinational sub-module, dobra_xor:
  - Parameter LARGURA_BEAT.
  - Reduces a beat to 8 bits by XOR of its bytes.
  - Shared with the write-side hash generator so both ends compute identical values.

Test Plan:
1. All-zero line, 8 beats, ultimo on beat 7, hash_esperado 0x00 → saida_valida one cycle after beat 7; hash_calculado 0x00, hash_ok 1, erro 0.
2. Line with only byte 0 = 0xA5, hash_esperado 0x5A → hash_calculado 0xA5, hash_ok 0, erro 0. Same line with hash_esperado 0xA5 → hash_ok 1.
3. ultimo asserted on beat 3 of a line with bytes 0x11 in beat 0 → result after beat 3; erro_enquadramento 1, hash_ok 0, hash_calculado equals the XOR of beats 0-3.
4. 8 beats with ultimo never set → terminates after beat 7 with erro 1. The following beat starts a fresh line, and its hash_esperado is captured.
5. saida_pronta held low 5 cycles in RESULTADO, with entrada_valida high → outputs stable, entrada_pronta 0, no beat consumed. On release, OCIOSO the next cycle, and the first beat is accepted.
6. rst_n pulsed low after 4 accepted beats → all outputs 0, no saida_valida. A complete new line, where XOR of bytes = 0x3C and hash_esperado 0x3C, then yields hash_ok 1.

Source files
------------

// File: rtl/verificador_hash_pkg.sv
// Shared definitions for the cache-line XOR hash checker and its write-side twin.
package verificador_hash_pkg;

    localparam int LARGURA_HASH = 8;

    typedef enum logic [1:0] {
        OCIOSO,
        ACUMULANDO,
        RESULTADO
    } estado_t;

    function automatic int calc_num_beats(input int largura_linha, input int largura_beat);
        return largura_linha / largura_beat;
    endfunction

endpackage

// File: rtl/verificador_hash_dobra_xor.sv
// Folds one beat down to a hash byte by XOR of all its bytes; also used by the write-side generator.
module dobra_xor
    import verificador_hash_pkg::*;
#(
    parameter int LARGURA_BEAT = 64
) (
    input  logic [LARGURA_BEAT-1:0] dados_i,
    output logic [LARGURA_HASH-1:0] dobra_o
);

    always_comb begin
        dobra_o = '0;
        for (int k = 0; k < LARGURA_BEAT / LARGURA_HASH; k++) begin
            dobra_o = dobra_o ^ dados_i[LARGURA_HASH*k +: LARGURA_HASH];
        end
    end

endmodule

// File: rtl/verificador_hash.sv
// Read-side line hash checker: folds streamed beats into a running XOR and
// compares it with the hash captured alongside beat 0.
module verificador_hash
    import verificador_hash_pkg::*;
#(
    parameter int LARGURA_LINHA = 512,
    parameter int LARGURA_BEAT  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    entrada_valida,
    output logic                    entrada_pronta,
    input  logic [LARGURA_BEAT-1:0] entrada_dados,
    input  logic                    entrada_ultimo,
    input  logic [LARGURA_HASH-1:0] hash_esperado,
    output logic                    saida_valida,
    input  logic                    saida_pronta,
    output logic [LARGURA_HASH-1:0] hash_calculado,
    output logic                    hash_ok,
    output logic                    erro_enquadramento
);

    localparam int NUM_BEATS = calc_num_beats(LARGURA_LINHA, LARGURA_BEAT);
    localparam int CONT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    estado_t                 estado_q;
    logic [LARGURA_HASH-1:0] acc_q;
    logic [LARGURA_HASH-1:0] esperado_q;
    logic [CONT_W-1:0]       cont_q;
    logic                    saida_valida_q;
    logic [LARGURA_HASH-1:0] hash_calculado_q;
    logic                    hash_ok_q;
    logic                    erro_q;

    logic [LARGURA_HASH-1:0] dobra;
    logic [LARGURA_HASH-1:0] acc_d;
    logic [LARGURA_HASH-1:0] esperado_d;
    logic [CONT_W-1:0]       cont_d;
    logic                    aceita;
    logic                    ultimo_indice;
    logic                    termina;
    logic                    erro_d;

    dobra_xor #(
        .LARGURA_BEAT(LARGURA_BEAT)
    ) u_dobra (
        .dados_i (entrada_dados),
        .dobra_o (dobra)
    );

    assign entrada_pronta = (estado_q != RESULTADO);
    assign aceita         = entrada_valida && entrada_pronta;

    // Beat 0 restarts the accumulator and captures the expected hash; later beats fold in.
    always_comb begin
        acc_d         = acc_q ^ dobra;
        esperado_d    = esperado_q;
        cont_d        = cont_q + 1'b1;
        ultimo_indice = (cont_q == CONT_W'(NUM_BEATS - 1));
        if (estado_q == OCIOSO) begin
            acc_d         = dobra;
            esperado_d    = hash_esperado;
            cont_d        = CONT_W'(1);
            ultimo_indice = (NUM_BEATS == 1);
        end
        termina = entrada_ultimo || ultimo_indice;
        erro_d  = (entrada_ultimo != ultimo_indice);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q         <= OCIOSO;
            acc_q            <= '0;
            esperado_q       <= '0;
            cont_q           <= '0;
            saida_valida_q   <= 1'b0;
            hash_calculado_q <= '0;
            hash_ok_q        <= 1'b0;
            erro_q           <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO, ACUMULANDO: begin
                    if (aceita) begin
                        acc_q      <= acc_d;
                        esperado_q <= esperado_d;
                        cont_q     <= cont_d;
                        if (termina) begin
                            estado_q         <= RESULTADO;
                            saida_valida_q   <= 1'b1;
                            hash_calculado_q <= acc_d;
                            erro_q           <= erro_d;
                            hash_ok_q        <= (acc_d == esperado_d) && !erro_d;
                        end else begin
                            estado_q <= ACUMULANDO;
                        end
                    end
                end
                RESULTADO: begin
                    if (saida_pronta) begin
                        estado_q       <= OCIOSO;
                        saida_valida_q <= 1'b0;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign saida_valida       = saida_valida_q;
    assign hash_calculado     = hash_calculado_q;
    assign hash_ok            = hash_ok_q;
    assign erro_enquadramento = erro_q;

endmodule

// File: tb/tb_verificador_hash.sv
// Directed self-checking bench for verificador_hash at default sizes (8 beats of 64 bits).
module tb_verificador_hash;

    logic        clk;
    logic        rst_n;
    logic        entrada_valida;
    logic        entrada_pronta;
    logic [63:0] entrada_dados;
    logic        entrada_ultimo;
    logic [7:0]  hash_esperado;
    logic        saida_valida;
    logic        saida_pronta;
    logic [7:0]  hash_calculado;
    logic        hash_ok;
    logic        erro_enquadramento;

    int testsRun    = 0;
    int testsFailed = 0;

    verificador_hash dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .entrada_valida     (entrada_valida),
        .entrada_pronta     (entrada_pronta),
        .entrada_dados      (entrada_dados),
        .entrada_ultimo     (entrada_ultimo),
        .hash_esperado      (hash_esperado),
        .saida_valida       (saida_valida),
        .saida_pronta       (saida_pronta),
        .hash_calculado     (hash_calculado),
        .hash_ok            (hash_ok),
        .erro_enquadramento (erro_enquadramento)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives beats [inicio, fim] of a line; the real hash goes with beat 0, a decoy with the rest.
    task automatic enviar_beats(input logic [511:0] linha, input int inicio, input int fim,
                                input int ultimo_em, input logic [7:0] h);
        for (int i = inicio; i <= fim; i++) begin
            entrada_valida = 1'b1;
            entrada_dados  = linha[i*64 +: 64];
            entrada_ultimo = (i == ultimo_em);
            hash_esperado  = (i == 0) ? h : ~h;
            @(posedge clk);
            #1;
        end
        entrada_valida = 1'b0;
        entrada_ultimo = 1'b0;
    endtask

    task automatic consumir();
        saida_pronta = 1'b1;
        @(posedge clk);
        #1;
        saida_pronta = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        testsRun++;
        if (saida_valida !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valida got %0b want 0", saida_valida); end
        testsRun++;
        if (hash_calculado !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_hash got %02h want 00", hash_calculado); end
        testsRun++;
        if (hash_ok !== 1'b0 || erro_enquadramento !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_flags got ok=%0b erro=%0b want 0 0", hash_ok, erro_enquadramento); end
        testsRun++;
        if (entrada_pronta !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_pronta got %0b want 1", entrada_pronta); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_linha_zero();
        logic [511:0] linha = '0;
        enviar_beats(linha, 0, 6, 7, 8'h00);
        testsRun++;
        if (saida_valida !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_cedo got valida=%0b want 0", saida_valida); end
        enviar_beats(linha, 7, 7, 7, 8'h00);
        testsRun++;
        if (saida_valida !== 1'b1) begin testsFailed++; $display("[TB] FAIL zero_valida got %0b want 1", saida_valida); end
        testsRun++;
        if (hash_calculado !== 8'h00 || hash_ok !== 1'b1 || erro_enquadramento !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL zero_resultado got hash=%02h ok=%0b erro=%0b want 00 1 0", hash_calculado, hash_ok, erro_enquadramento);
        end
        consumir();
        testsRun++;
        if (saida_valida !== 1'b0 || entrada_pronta !== 1'b1) begin testsFailed++; $display("[TB] FAIL zero_consumo got valida=%0b pronta=%0b want 0 1", saida_valida, entrada_pronta); end
    endtask

    task automatic test_byte_unico();
        logic [511:0] linha = '0;
        linha[7:0] = 8'hA5;
        enviar_beats(linha, 0, 7, 7, 8'h5A);
        testsRun++;
        if (hash_calculado !== 8'hA5 || hash_ok !== 1'b0 || erro_enquadramento !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL a5_errado got hash=%02h ok=%0b erro=%0b want a5 0 0", hash_calculado, hash_ok, erro_enquadramento);
        end
        consumir();
        enviar_beats(linha, 0, 7, 7, 8'hA5);
        testsRun++;
        if (hash_calculado !== 8'hA5 || hash_ok !== 1'b1 || erro_enquadramento !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL a5_certo got hash=%02h ok=%0b erro=%0b want a5 1 0", hash_calculado, hash_ok, erro_enquadramento);
        end
        consumir();
    endtask

    task automatic test_ultimo_cedo();
        logic [511:0] linha = '0;
        linha[0*64 + 7  -: 8] = 8'h11;
        linha[1*64 + 15 -: 8] = 8'h22;
        linha[2*64 + 7  -: 8] = 8'h44;
        linha[3*64 + 63 -: 8] = 8'h88;
        enviar_beats(linha, 0, 3, 3, 8'hFF);
        testsRun++;
        if (saida_valida !== 1'b1) begin testsFailed++; $display("[TB] FAIL cedo_valida got %0b want 1", saida_valida); end
        testsRun++;
        if (hash_calculado !== 8'hFF || hash_ok !== 1'b0 || erro_enquadramento !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL cedo_resultado got hash=%02h ok=%0b erro=%0b want ff 0 1", hash_calculado, hash_ok, erro_enquadramento);
        end
        consumir();
    endtask

    task automatic test_ultimo_ausente();
        logic [511:0] linha = '0;
        for (int i = 0; i < 8; i++) linha[i*64 +: 8] = 8'(i + 1);
        enviar_beats(linha, 0, 7, -1, 8'h08);
        testsRun++;
        if (saida_valida !== 1'b1 || hash_calculado !== 8'h08 || hash_ok !== 1'b0 || erro_enquadramento !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ausente_resultado got v=%0b hash=%02h ok=%0b erro=%0b want 1 08 0 1", saida_valida, hash_calculado, hash_ok, erro_enquadramento);
        end
        consumir();
        linha = '0;
        linha[7:0] = 8'h03;
        enviar_beats(linha, 0, 7, 7, 8'h03);
        testsRun++;
        if (saida_valida !== 1'b1 || hash_calculado !== 8'h03 || hash_ok !== 1'b1 || erro_enquadramento !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ausente_nova got v=%0b hash=%02h ok=%0b erro=%0b want 1 03 1 0", saida_valida, hash_calculado, hash_ok, erro_enquadramento);
        end
        consumir();
    endtask

    task automatic test_contrapressao();
        logic [511:0] linha = '0;
        linha[7:0] = 8'h5A;
        enviar_beats(linha, 0, 7, 7, 8'h5A);
        entrada_valida = 1'b1;
        entrada_dados  = 64'h99;
        entrada_ultimo = 1'b1;
        hash_esperado  = 8'h99;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            testsRun++;
            if (entrada_pronta !== 1'b0 || saida_valida !== 1'b1 || hash_calculado !== 8'h5A || hash_ok !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL espera_%0d got pronta=%0b v=%0b hash=%02h ok=%0b want 0 1 5a 1", c, entrada_pronta, saida_valida, hash_calculado, hash_ok);
            end
        end
        consumir();
        testsRun++;
        if (saida_valida !== 1'b0 || entrada_pronta !== 1'b1) begin testsFailed++; $display("[TB] FAIL espera_libera got v=%0b pronta=%0b want 0 1", saida_valida, entrada_pronta); end
        @(posedge clk);
        #1;
        entrada_valida = 1'b0;
        entrada_ultimo = 1'b0;
        testsRun++;
        if (saida_valida !== 1'b1 || hash_calculado !== 8'h99 || hash_ok !== 1'b0 || erro_enquadramento !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL espera_prox got v=%0b hash=%02h ok=%0b erro=%0b want 1 99 0 1", saida_valida, hash_calculado, hash_ok, erro_enquadramento);
        end
        consumir();
    endtask

    task automatic test_reset_meio();
        logic [511:0] linha = '0;
        for (int i = 0; i < 8; i++) linha[i*64 +: 8] = 8'hC0 + 8'(i);
        enviar_beats(linha, 0, 3, -1, 8'h12);
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (saida_valida !== 1'b0 || hash_calculado !== 8'h00 || hash_ok !== 1'b0 || erro_enquadramento !== 1'b0 || entrada_pronta !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL meio_reset got v=%0b hash=%02h ok=%0b erro=%0b pronta=%0b want 0 00 0 0 1",
                     saida_valida, hash_calculado, hash_ok, erro_enquadramento, entrada_pronta);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        testsRun++;
        if (saida_valida !== 1'b0) begin testsFailed++; $display("[TB] FAIL meio_sem_saida got v=%0b want 0", saida_valida); end
        linha = '0;
        linha[7:0]             = 8'h0F;
        linha[5*64 + 31 -: 8]  = 8'h33;
        enviar_beats(linha, 0, 6, 7, 8'h3C);
        testsRun++;
        if (saida_valida !== 1'b0) begin testsFailed++; $display("[TB] FAIL meio_cedo got v=%0b want 0", saida_valida); end
        enviar_beats(linha, 7, 7, 7, 8'h3C);
        testsRun++;
        if (saida_valida !== 1'b1 || hash_calculado !== 8'h3C || hash_ok !== 1'b1 || erro_enquadramento !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL meio_nova got v=%0b hash=%02h ok=%0b erro=%0b want 1 3c 1 0", saida_valida, hash_calculado, hash_ok, erro_enquadramento);
        end
        consumir();
    endtask

    initial begin
        rst_n          = 1'b0;
        entrada_valida = 1'b0;
        entrada_dados  = '0;
        entrada_ultimo = 1'b0;
        hash_esperado  = '0;
        saida_pronta   = 1'b0;
        test_reset();
        test_linha_zero();
        test_byte_unico();
        test_ultimo_cedo();
        test_ultimo_ausente();
        test_contrapressao();
        test_reset_meio();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
